// File: rtl/fdtd_update_engine.sv
// fdtd_update_engine: one Hy or Ez FDTD update pass over a buffered 1-D segment.
// Streams both old-field RAMs in address order and writes updates into the selected new-field RAM.
module fdtd_update_engine #(
    parameter int FDTD_DATA_WIDTH   = 32,
    parameter int FRAC_BITS         = 16,
    parameter int BUFFER_ADDR_WIDTH = 6,
    parameter int FDTD_BUFFER_DEPTH = 64
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         start_hy_i,
    input  logic                         start_ez_i,
    input  logic [BUFFER_ADDR_WIDTH:0]   size_i,
    input  logic [FDTD_DATA_WIDTH-1:0]   coef_h_i,
    input  logic [FDTD_DATA_WIDTH-1:0]   coef_e_i,
    output logic                         rd_Hy_old_en_o,
    output logic                         rd_Ez_old_en_o,
    output logic [BUFFER_ADDR_WIDTH-1:0] rd_Hy_old_addr_o,
    output logic [BUFFER_ADDR_WIDTH-1:0] rd_Ez_old_addr_o,
    input  logic [FDTD_DATA_WIDTH-1:0]   Hy_old_i,
    input  logic [FDTD_DATA_WIDTH-1:0]   Ez_old_i,
    output logic                         wrt_Hy_n_en_o,
    output logic                         wrt_Ez_n_en_o,
    output logic [BUFFER_ADDR_WIDTH-1:0] wrt_Hy_n_addr_o,
    output logic [BUFFER_ADDR_WIDTH-1:0] wrt_Ez_n_addr_o,
    output logic [FDTD_DATA_WIDTH-1:0]   Hy_n_o,
    output logic [FDTD_DATA_WIDTH-1:0]   Ez_n_o,
    output logic                         busy_o,
    output logic                         done_o
);
    localparam int W  = FDTD_DATA_WIDTH;
    localparam int AW = BUFFER_ADDR_WIDTH;
    localparam int PW = W + FRAC_BITS;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic          mode_hy_q, mode_hy_d;
    logic [AW:0]   n_q, n_d, n_last;
    logic [W-1:0]  coef_q, coef_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          d0_v_q, d0_v_d, d1_v_q, d1_v_d;
    logic [AW-1:0] d0_idx_q, d0_idx_d, d1_idx_q, d1_idx_d;
    logic [W-1:0]  hy_p_q, hy_p_d, ez_p_q, ez_p_d;
    logic          m_v_q, m_v_d;
    logic [AW-1:0] m_idx_q, m_idx_d;
    logic [W-1:0]  m_prod_q, m_prod_d, m_old_q, m_old_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [W-1:0]  wr_data_q, wr_data_d;
    logic          start_acc, rd_en, c_v, c_bnd;
    logic [AW-1:0] c_idx;
    logic [W-1:0]  c_diff, c_old;
    logic [PW-1:0] prod;

    assign start_acc = (state_q == IDLE) && (start_hy_i || start_ez_i);
    assign n_last    = n_q - 1'b1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_acc ? RUN : IDLE;
            RUN:     state_d = (n_q == '0) ? DONE : ({1'b0, cnt_q} == n_last) ? DRAIN : RUN;
            DRAIN:   state_d = (wr_en_q && {1'b0, wr_addr_q} == n_last) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_en            = (state_q == RUN) && (n_q != '0);
        rd_Hy_old_en_o   = rd_en;
        rd_Ez_old_en_o   = rd_en;
        rd_Hy_old_addr_o = cnt_q;
        rd_Ez_old_addr_o = cnt_q;
        wrt_Hy_n_en_o    = wr_en_q && mode_hy_q;
        wrt_Ez_n_en_o    = wr_en_q && !mode_hy_q;
        wrt_Hy_n_addr_o  = wr_addr_q;
        wrt_Ez_n_addr_o  = wr_addr_q;
        Hy_n_o           = wr_data_q;
        Ez_n_o           = wr_data_q;
        busy_o           = state_q != IDLE;
        done_o           = state_q == DONE;
    end

    // Hy needs Ez_old[k+1], so it computes one cycle after Ez does, from the delayed copies.
    always_comb begin
        mode_hy_d = start_acc ? start_hy_i : mode_hy_q;
        n_d       = start_acc ? ((size_i > (AW+1)'(FDTD_BUFFER_DEPTH)) ? (AW+1)'(FDTD_BUFFER_DEPTH) : size_i) : n_q;
        coef_d    = start_acc ? (start_hy_i ? coef_h_i : coef_e_i) : coef_q;
        cnt_d     = start_acc ? '0 : rd_en ? cnt_q + 1'b1 : cnt_q;
        d0_v_d    = rd_en;
        d0_idx_d  = cnt_q;
        d1_v_d    = d0_v_q;
        d1_idx_d  = d0_idx_q;
        hy_p_d    = d0_v_q ? Hy_old_i : hy_p_q;
        ez_p_d    = d0_v_q ? Ez_old_i : ez_p_q;
        c_v       = mode_hy_q ? d1_v_q : d0_v_q;
        c_idx     = mode_hy_q ? d1_idx_q : d0_idx_q;
        c_diff    = mode_hy_q ? Ez_old_i - ez_p_q : Hy_old_i - hy_p_q;
        c_old     = mode_hy_q ? hy_p_q : Ez_old_i;
        c_bnd     = mode_hy_q ? ({1'b0, c_idx} == n_last) : (c_idx == '0);
        prod      = {{FRAC_BITS{c_diff[W-1]}}, c_diff} * {{FRAC_BITS{coef_q[W-1]}}, coef_q};
        m_v_d     = c_v;
        m_idx_d   = c_idx;
        m_prod_d  = c_bnd ? '0 : W'(prod >> FRAC_BITS);
        m_old_d   = c_old;
        wr_en_d   = m_v_q;
        wr_addr_d = m_idx_q;
        wr_data_d = m_old_q + m_prod_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_hy_q <= 1'b0;
            n_q       <= '0;
            coef_q    <= '0;
            cnt_q     <= '0;
            d0_v_q    <= 1'b0;
            d0_idx_q  <= '0;
            d1_v_q    <= 1'b0;
            d1_idx_q  <= '0;
            hy_p_q    <= '0;
            ez_p_q    <= '0;
            m_v_q     <= 1'b0;
            m_idx_q   <= '0;
            m_prod_q  <= '0;
            m_old_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            mode_hy_q <= mode_hy_d;
            n_q       <= n_d;
            coef_q    <= coef_d;
            cnt_q     <= cnt_d;
            d0_v_q    <= d0_v_d;
            d0_idx_q  <= d0_idx_d;
            d1_v_q    <= d1_v_d;
            d1_idx_q  <= d1_idx_d;
            hy_p_q    <= hy_p_d;
            ez_p_q    <= ez_p_d;
            m_v_q     <= m_v_d;
            m_idx_q   <= m_idx_d;
            m_prod_q  <= m_prod_d;
            m_old_q   <= m_old_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end
endmodule

// File: tb/tb_fdtd_update_engine.sv
// tb_fdtd_update_engine: randomized and directed passes checked every cycle against a behavioural FDTD model.
module tb_fdtd_update_engine;
    localparam int D = 64;

    logic        CLK = 0, RST_N = 0;
    logic        start_hy_i = 0, start_ez_i = 0;
    logic [6:0]  size_i = 0;
    logic [31:0] coef_h_i = 0, coef_e_i = 0;
    logic        rd_Hy_old_en_o, rd_Ez_old_en_o, wrt_Hy_n_en_o, wrt_Ez_n_en_o, busy_o, done_o;
    logic [5:0]  rd_Hy_old_addr_o, rd_Ez_old_addr_o, wrt_Hy_n_addr_o, wrt_Ez_n_addr_o;
    logic [31:0] Hy_n_o, Ez_n_o;
    logic [31:0] hy_rd = 0, ez_rd = 0;

    always #5 CLK = ~CLK;

    fdtd_update_engine dut (
        .CLK(CLK), .RST_N(RST_N), .start_hy_i(start_hy_i), .start_ez_i(start_ez_i),
        .size_i(size_i), .coef_h_i(coef_h_i), .coef_e_i(coef_e_i),
        .rd_Hy_old_en_o(rd_Hy_old_en_o), .rd_Ez_old_en_o(rd_Ez_old_en_o),
        .rd_Hy_old_addr_o(rd_Hy_old_addr_o), .rd_Ez_old_addr_o(rd_Ez_old_addr_o),
        .Hy_old_i(hy_rd), .Ez_old_i(ez_rd),
        .wrt_Hy_n_en_o(wrt_Hy_n_en_o), .wrt_Ez_n_en_o(wrt_Ez_n_en_o),
        .wrt_Hy_n_addr_o(wrt_Hy_n_addr_o), .wrt_Ez_n_addr_o(wrt_Ez_n_addr_o),
        .Hy_n_o(Hy_n_o), .Ez_n_o(Ez_n_o), .busy_o(busy_o), .done_o(done_o)
    );

    logic [31:0] hy_old[D], ez_old[D], hy_n_mem[D], ez_n_mem[D], exp_mem[D];
    int cyc = 0, errors = 0, checks = 0;
    int hy_wr_cnt, ez_wr_cnt, done_cnt, first_wr, done_at, st;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (rd_Hy_old_en_o) hy_rd <= hy_old[rd_Hy_old_addr_o];
        if (rd_Ez_old_en_o) ez_rd <= ez_old[rd_Ez_old_addr_o];
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Q16.16 product, floored, wrapped to 32 bits
    function automatic logic [31:0] fmul(logic [31:0] d, logic [31:0] c);
        longint p;
        p = longint'($signed(d)) * longint'($signed(c));
        p = p >>> 16;
        return p[31:0];
    endfunction

    bit          have = 0, m_hy, erd, ewr, edone, ebusy;
    int          t0, m_n, m_done_rel, rel, lat, widx;
    logic [31:0] m_coef;

    always @(negedge CLK) begin
        if (!RST_N) begin
            have = 0;
            chk("reset_ctl", {26'd0, rd_Hy_old_en_o, rd_Ez_old_en_o, wrt_Hy_n_en_o, wrt_Ez_n_en_o, busy_o, done_o}, 0);
            chk("reset_addr", {8'd0, rd_Hy_old_addr_o, rd_Ez_old_addr_o, wrt_Hy_n_addr_o, wrt_Ez_n_addr_o}, 0);
            chk("reset_data", Hy_n_o | Ez_n_o, 0);
        end else begin
            rel   = cyc - t0;
            lat   = m_hy ? 5 : 4;
            erd   = have && rel >= 1 && rel <= m_n;
            ewr   = have && rel >= lat && rel < lat + m_n;
            edone = have && rel == m_done_rel;
            ebusy = have && rel >= 1 && rel <= m_done_rel;
            chk("rd_en", {30'd0, rd_Hy_old_en_o, rd_Ez_old_en_o}, {30'd0, erd, erd});
            if (erd) chk("rd_addr", {20'd0, rd_Hy_old_addr_o, rd_Ez_old_addr_o}, {20'd0, 6'(rel - 1), 6'(rel - 1)});
            chk("wr_en", {30'd0, wrt_Hy_n_en_o, wrt_Ez_n_en_o}, {30'd0, ewr && m_hy, ewr && !m_hy});
            if (ewr) begin
                widx = rel - lat;
                chk("wr_addr", 32'(m_hy ? wrt_Hy_n_addr_o : wrt_Ez_n_addr_o), 32'(widx));
                chk("wr_data", m_hy ? Hy_n_o : Ez_n_o, exp_mem[widx]);
            end
            chk("done_busy", {30'd0, done_o, busy_o}, {30'd0, edone, ebusy});
            if (wrt_Hy_n_en_o) begin hy_n_mem[wrt_Hy_n_addr_o] = Hy_n_o; hy_wr_cnt++; end
            if (wrt_Ez_n_en_o) begin ez_n_mem[wrt_Ez_n_addr_o] = Ez_n_o; ez_wr_cnt++; end
            if ((wrt_Hy_n_en_o || wrt_Ez_n_en_o) && first_wr < 0) first_wr = cyc;
            if (done_o) begin done_cnt++; done_at = cyc; end
            if ((start_hy_i || start_ez_i) && !ebusy) begin
                have = 1;
                t0 = cyc;
                m_hy = start_hy_i;
                m_n = (size_i > 64) ? 64 : int'(size_i);
                m_coef = start_hy_i ? coef_h_i : coef_e_i;
                m_done_rel = (m_n == 0) ? 2 : (m_hy ? 5 : 4) + m_n;
                for (int k = 0; k < m_n; k++) begin
                    if (m_hy) begin
                        exp_mem[k] = hy_old[k];
                        if (k != m_n - 1) exp_mem[k] = hy_old[k] + fmul(ez_old[k+1] - ez_old[k], m_coef);
                    end else begin
                        exp_mem[k] = ez_old[k];
                        if (k != 0) exp_mem[k] = ez_old[k] + fmul(hy_old[k] - hy_old[k-1], m_coef);
                    end
                end
            end
        end
    end

    task automatic do_pass(bit sh, bit se, int size, logic [31:0] ch, logic [31:0] ce);
        @(posedge CLK); #1;
        for (int i = 0; i < D; i++) begin hy_n_mem[i] = 32'hDEADBEEF; ez_n_mem[i] = 32'hDEADBEEF; end
        hy_wr_cnt = 0; ez_wr_cnt = 0; done_cnt = 0; first_wr = -1; done_at = -1;
        start_hy_i = sh; start_ez_i = se; size_i = 7'(size); coef_h_i = ch; coef_e_i = ce; st = cyc;
        @(posedge CLK); #1;
        start_hy_i = 0; start_ez_i = 0;
        size_i = 7'($urandom); coef_h_i = $urandom; coef_e_i = $urandom;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < D; i++) begin hy_old[i] = $urandom; ez_old[i] = $urandom; end
    endtask

    int h_before, e_before;

    initial begin
        rand_fields();
        repeat (3) @(posedge CLK);
        #1 RST_N = 1;

        // Hy N=8, ch=0.5, Ez ramp
        for (int i = 0; i < D; i++) begin hy_old[i] = 0; ez_old[i] = i << 16; end
        do_pass(1, 0, 8, 32'h00008000, 0);
        repeat (16) @(posedge CLK);
        for (int k = 0; k < 7; k++) chk("t1_hy_n", hy_n_mem[k], 32'h00008000);
        chk("t1_hy_n7", hy_n_mem[7], 0);
        chk("t1_first_wr", 32'(first_wr - st), 5);
        chk("t1_done_at", 32'(done_at - st), 13);
        chk("t1_ez_cnt", 32'(ez_wr_cnt), 0);

        // Ez N=4, ce=1.0
        for (int i = 0; i < D; i++) ez_old[i] = 32'h00010000;
        hy_old[0] = 0; hy_old[1] = 32'h10000; hy_old[2] = 32'h30000; hy_old[3] = 32'h60000;
        do_pass(0, 1, 4, 0, 32'h00010000);
        repeat (12) @(posedge CLK);
        chk("t2_ez_n0", ez_n_mem[0], 32'h10000);
        chk("t2_ez_n1", ez_n_mem[1], 32'h20000);
        chk("t2_ez_n2", ez_n_mem[2], 32'h30000);
        chk("t2_ez_n3", ez_n_mem[3], 32'h40000);
        chk("t2_first_wr", 32'(first_wr - st), 4);
        chk("t2_hy_cnt", 32'(hy_wr_cnt), 0);

        // negative coefficient floors to -1
        hy_old[0] = 0; hy_old[1] = 1; ez_old[0] = 32'h55; ez_old[1] = 32'h12340000;
        do_pass(0, 1, 2, 0, 32'hFFFF0000);
        repeat (10) @(posedge CLK);
        chk("t3_ez_n0", ez_n_mem[0], 32'h55);
        chk("t3_neg_floor", ez_n_mem[1], 32'h1233FFFF);

        // add wraps
        ez_old[1] = 32'h7FFFFFFF;
        do_pass(0, 1, 2, 0, 32'h00010000);
        repeat (10) @(posedge CLK);
        chk("t3_wrap", ez_n_mem[1], 32'h80000000);

        // N=0
        do_pass(0, 1, 0, 0, 32'h00010000);
        repeat (8) @(posedge CLK);
        chk("t4_n0_writes", 32'(hy_wr_cnt + ez_wr_cnt), 0);
        chk("t4_n0_done_at", 32'(done_at - st), 2);

        // N=1 Hy passthrough
        rand_fields();
        do_pass(1, 0, 1, 32'h00030000, 0);
        repeat (10) @(posedge CLK);
        chk("t5_n1_hy", hy_n_mem[0], hy_old[0]);
        chk("t5_n1_cnt", 32'(hy_wr_cnt), 1);

        // clamp
        do_pass(0, 1, 100, 0, 32'h00018000);
        repeat (80) @(posedge CLK);
        chk("t6_clamp_cnt", 32'(ez_wr_cnt), 64);

        // both starts together: Hy wins
        do_pass(1, 1, 10, 32'h00004000, 32'h00020000);
        repeat (20) @(posedge CLK);
        chk("t7_hy_cnt", 32'(hy_wr_cnt), 10);
        chk("t7_ez_cnt", 32'(ez_wr_cnt), 0);

        // start while busy is ignored
        do_pass(0, 1, 12, 0, 32'hFFFE8000);
        repeat (4) @(posedge CLK);
        #1 start_ez_i = 1; start_hy_i = 1;
        @(posedge CLK); #1 start_ez_i = 0; start_hy_i = 0;
        repeat (20) @(posedge CLK);
        chk("t8_done_cnt", 32'(done_cnt), 1);
        chk("t8_ez_cnt", 32'(ez_wr_cnt), 12);
        chk("t8_hy_cnt", 32'(hy_wr_cnt), 0);

        // reset at t0+6 of an N=16 pass
        do_pass(1, 0, 16, 32'h00012345, 0);
        repeat (5) @(posedge CLK);
        #1 RST_N = 0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1;
        h_before = hy_wr_cnt; e_before = ez_wr_cnt;
        repeat (30) @(posedge CLK);
        chk("t9_no_writes", 32'(hy_wr_cnt + ez_wr_cnt), 32'(h_before + e_before));
        chk("t9_no_done", 32'(done_cnt), 0);
        rand_fields();
        do_pass(1, 0, 16, 32'hFFF00000, 0);
        repeat (26) @(posedge CLK);
        chk("t9_full_pass", 32'(hy_wr_cnt), 16);
        chk("t9_done_cnt", 32'(done_cnt), 1);

        // randomized passes
        for (int p = 0; p < 24; p++) begin
            int n;
            bit hy;
            rand_fields();
            n = $urandom_range(0, 75);
            hy = 1'($urandom);
            do_pass(hy, !hy, n, $urandom, $urandom);
            repeat ((n > 64 ? 64 : n) + 10) @(posedge CLK);
            chk("rnd_done_cnt", 32'(done_cnt), 1);
            chk("rnd_wr_cnt", 32'(hy ? hy_wr_cnt : ez_wr_cnt), 32'(n > 64 ? 64 : n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fdtd_update_engine.md
Name: fdtd_update_engine

Overview:
- Computes one FDTD field-update pass over a buffered 1-D segment. Hy pass: Hy_n[k] = Hy_old[k] + ch*(Ez_old[k+1]-Ez_old[k]). Ez pass: Ez_n[k] = Ez_old[k] + ce*(Hy_old[k]-Hy_old[k-1]).
- Sits directly downstream of the field buffer's previous-timestep RAMs and upstream of its current-timestep RAMs. It drives the buffer's rd_*_old ports and wrt_*_n ports.
- Started by the top-level controller once buffering ends; reports completion so the controller can begin write-back to data memory.

Parameters:
FDTD_DATA_WIDTH, 32, field/coefficient word width, signed fixed point
FRAC_BITS, 16, fractional bits of field and coefficient words (Q16.16)
BUFFER_ADDR_WIDTH, 6, buffer RAM address width
FDTD_BUFFER_DEPTH, 64, buffer RAM depth; maximum segment length

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
start_hy_i  in  1  one-cycle pulse: begin Hy pass
start_ez_i  in  1  one-cycle pulse: begin Ez pass
size_i  in  BUFFER_ADDR_WIDTH+1  segment length N, sampled at start
coef_h_i  in  FDTD_DATA_WIDTH  ch, sampled at start
coef_e_i  in  FDTD_DATA_WIDTH  ce, sampled at start
rd_Hy_old_en_o  out  1  read enable to Hy_old RAM
rd_Ez_old_en_o  out  1  read enable to Ez_old RAM
rd_Hy_old_addr_o  out  BUFFER_ADDR_WIDTH  read address, Hy_old
rd_Ez_old_addr_o  out  BUFFER_ADDR_WIDTH  read address, Ez_old
Hy_old_i  in  FDTD_DATA_WIDTH  Hy_old RAM data, valid 1 cycle after read enable
Ez_old_i  in  FDTD_DATA_WIDTH  Ez_old RAM data, valid 1 cycle after read enable
wrt_Hy_n_en_o  out  1  write enable, Hy_n RAM
wrt_Ez_n_en_o  out  1  write enable, Ez_n RAM
wrt_Hy_n_addr_o  out  BUFFER_ADDR_WIDTH  write address, Hy_n
wrt_Ez_n_addr_o  out  BUFFER_ADDR_WIDTH  write address, Ez_n
Hy_n_o  out  FDTD_DATA_WIDTH  Hy_n write data
Ez_n_o  out  FDTD_DATA_WIDTH  Ez_n write data
busy_o  out  1  high from the cycle after an accepted start until done_o
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset, asynchronous: all outputs 0; FSM to IDLE; pipeline valid bits cleared. Reset mid-pass aborts with no further writes.
- FSM states:
  - IDLE -> RUN on an accepted start.
  - RUN issues reads at addresses 0..N-1, one per cycle, no stalls. Then -> DRAIN.
  - DRAIN waits until the last write retires. Then -> DONE.
  - DONE pulses done_o for one cycle. Then -> IDLE.
- Start handling:
  - Starts are accepted only in IDLE; a start in any other state is ignored.
  - If start_hy_i and start_ez_i arrive in the same cycle, Hy wins and the Ez start is dropped.
- size_i: N > FDTD_BUFFER_DEPTH is clamped to the depth. N = 0 means no reads and no writes; done_o pulses 2 cycles after start.
- Timing: the start pulse is cycle t0.
  - Reads: address k is issued at cycle t0+1+k with both rd enables high and both addresses = k. Both RAMs are read in both modes.
  - Pipeline: read data registered -> difference and multiply registered -> add and write-port registers.
  - Ez pass: index k is written at cycle t0+4+k.
  - Hy pass: index k is written at cycle t0+5+k, because it waits for Ez_old[k+1].
  - Writes are in ascending address order, exactly N write-enable cycles. Only the selected field's write port is ever asserted.
  - done_o is asserted the cycle after the last write.
- Arithmetic:
  - Differences are full-width signed subtraction, wrapping.
  - The product is 2*FDTD_DATA_WIDTH signed, arithmetic-shifted right by FRAC_BITS (floor), then truncated to FDTD_DATA_WIDTH.
  - The add wraps. No saturation anywhere.
- Boundaries:
  - Hy_n[N-1] = Hy_old[N-1], written at its normal slot.
  - Ez_n[0] = Ez_old[0].
  - N = 1 in either pass is a single passthrough write at address 0.
- Coefficients and N are latched at start; changes during a pass have no effect.
- Address counters never wrap within a pass, because N is bounded by the depth.

Test Plan:
- Hy pass, N=8, ch=0x00008000 (0.5), Ez_old[k]=k<<16, Hy_old=0 -> Hy_n[0..6]=0x00008000, Hy_n[7]=0. First write at t0+5, done_o at t0+13.
- Ez pass, N=4, ce=0x00010000 (1.0), Hy_old={0,0x10000,0x30000,0x60000}, Ez_old=0x10000 everywhere -> Ez_n={0x10000,0x20000,0x30000,0x40000}. Writes at t0+4..t0+7; wrt_Hy_n_en_o stays 0 throughout.
- Negative and wrap arithmetic: ce=0xFFFF0000 (-1.0), Hy_old[1]-Hy_old[0]=0x00000001 -> product floors to -1; Ez_n[1]=Ez_old[1]-1. Also Ez_old=0x7FFFFFFF with +1 -> 0x80000000 (wraps).
- Edge sizes: N=0 -> no rd or wrt enables, done_o at t0+2. N=1 Hy -> single write Hy_n[0]=Hy_old[0]. size_i=100 -> clamped to 64 writes.
- Collisions: start_hy_i and start_ez_i in the same cycle -> Hy pass only. start_ez_i while busy_o=1 -> ignored; exactly one done_o.
- Reset mid-pass: RST_N low at t0+6 of an N=16 pass -> all outputs 0 immediately. After release, no writes occur until a new start; a new start runs a full, correct pass.
